// File: rtl/lc4_writeback.sv
// lc4_writeback: execute-to-writeback stage downstream of lc4_alu.
//
// Registers the ALU result, destination index and write enable, and
// maintains the architectural NZP condition code. MUL (which the ALU
// returns as 0) is computed here with a fixed-latency shift-add
// multiplier taking WORD_SIZE cycles, during which upstream is stalled.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_valid / o_ready    upstream handshake
//   i_flush              kill in-flight and incoming instruction
//   i_insn               instruction word (MUL decode only)
//   i_alu_result         ALU result for i_insn
//   i_r1data, i_r2data   MUL operands
//   i_rd_sel, i_rd_we    destination index / write enable
//   i_nzp_we             instruction updates NZP
//   o_valid              one-cycle retire pulse
//   o_rd_we/sel/data     register-file write port
//   o_nzp                condition code {N,Z,P}
//   dbg_state            FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: an instruction transfers on a rising edge where
// i_valid && o_ready; o_ready depends only on registered state, never on
// i_valid. There is no downstream backpressure: o_valid is a pulse the
// register file always consumes.

module lc4_writeback #(
  parameter int WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_flush,
  input  logic [15:0]          i_insn,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
  input  logic [2:0]           i_rd_sel,
  input  logic                 i_rd_we,
  input  logic                 i_nzp_we,
  output logic                 o_valid,
  output logic                 o_rd_we,
  output logic [2:0]           o_rd_sel,
  output logic [WORD_SIZE-1:0] o_rd_data,
  output logic [2:0]           o_nzp,
  output logic                 dbg_state
);

  localparam int CW = $clog2(WORD_SIZE + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] acc;
  logic [WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0] mplier;
  logic [CW-1:0]        count;
  logic [2:0]           mul_rd_sel;
  logic                 mul_rd_we;
  logic                 mul_nzp_we;

  logic                 is_mul;
  logic                 accept;
  logic [WORD_SIZE-1:0] mul_sum;
  logic                 unused_insn_bits;

  assign is_mul    = (i_insn[15:12] == 4'b0001) && (i_insn[5:3] == 3'b001);
  assign o_ready   = (state == S_IDLE);
  assign accept    = i_valid && o_ready;
  assign dbg_state = (state == S_MUL);

  // Accumulator value after this cycle's step; on the final step this is
  // the product itself, so it is written straight to o_rd_data.
  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  assign unused_insn_bits = ^{i_insn[11:6], i_insn[2:0]};

  function automatic logic [2:0] nzp_of(input logic [WORD_SIZE-1:0] r);
    logic n;
    logic z;
    n = r[WORD_SIZE-1];
    z = (r == '0);
    return {n, z, !n && !z};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      mul_rd_sel <= 3'd0;
      mul_rd_we  <= 1'b0;
      mul_nzp_we <= 1'b0;
      o_valid    <= 1'b0;
      o_rd_we    <= 1'b0;
      o_rd_sel   <= 3'd0;
      o_rd_data  <= '0;
      o_nzp      <= 3'b010;
    end else if (i_flush) begin
      // Flush beats both a new transfer and MUL completion; NZP is kept.
      state   <= S_IDLE;
      o_valid <= 1'b0;
      o_rd_we <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            acc        <= '0;
            mcand      <= i_r1data;
            mplier     <= i_r2data;
            count      <= CW'(WORD_SIZE);
            mul_rd_sel <= i_rd_sel;
            mul_rd_we  <= i_rd_we;
            mul_nzp_we <= i_nzp_we;
            state      <= S_MUL;
            o_valid    <= 1'b0;
            o_rd_we    <= 1'b0;
          end else if (accept) begin
            o_valid   <= 1'b1;
            o_rd_we   <= i_rd_we;
            o_rd_sel  <= i_rd_sel;
            o_rd_data <= i_alu_result;
            if (i_nzp_we) o_nzp <= nzp_of(i_alu_result);
          end else begin
            o_valid <= 1'b0;
            o_rd_we <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= S_IDLE;
            o_valid   <= 1'b1;
            o_rd_we   <= mul_rd_we;
            o_rd_sel  <= mul_rd_sel;
            o_rd_data <= mul_sum;
            if (mul_nzp_we) o_nzp <= nzp_of(mul_sum);
          end else begin
            o_valid <= 1'b0;
            o_rd_we <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_rd_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_writeback.sv
// Testbench for lc4_writeback (WORD_SIZE = 64): directed vectors with
// hand-computed expected values. Inputs change on the falling edge and
// outputs are sampled on the falling edge.

module tb_lc4_writeback;

  localparam int W = 64;
  localparam logic [15:0] INSN_ADD = 16'h1600;  // ADD R3, ...
  localparam logic [15:0] INSN_MUL = 16'h1208;  // MUL ([5:3]=001)
  localparam logic [15:0] INSN_CMP = 16'h2000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_flush = 1'b0;
  logic [15:0]  i_insn = 16'h0;
  logic [W-1:0] i_alu_result = '0;
  logic [W-1:0] i_r1data = '0;
  logic [W-1:0] i_r2data = '0;
  logic [2:0]   i_rd_sel = 3'd0;
  logic         i_rd_we = 1'b0;
  logic         i_nzp_we = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic         o_rd_we;
  logic [2:0]   o_rd_sel;
  logic [W-1:0] o_rd_data;
  logic [2:0]   o_nzp;
  logic         dbg_state;

  always #5 clk = ~clk;

  lc4_writeback #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_insn(i_insn), .i_alu_result(i_alu_result),
    .i_r1data(i_r1data), .i_r2data(i_r2data), .i_rd_sel(i_rd_sel),
    .i_rd_we(i_rd_we), .i_nzp_we(i_nzp_we), .o_valid(o_valid),
    .o_rd_we(o_rd_we), .o_rd_sel(o_rd_sel), .o_rd_data(o_rd_data),
    .o_nzp(o_nzp), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] insn, input logic [W-1:0] alu,
                      input logic [W-1:0] r1, input logic [W-1:0] r2,
                      input logic [2:0] sel, input logic we, input logic nzp_we);
    i_valid      = 1'b1;
    i_insn       = insn;
    i_alu_result = alu;
    i_r1data     = r1;
    i_r2data     = r2;
    i_rd_sel     = sel;
    i_rd_we      = we;
    i_nzp_we     = nzp_we;
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  // Steps until o_valid, bounded; reports cycles spent and cycles with o_ready low.
  task automatic wait_valid(output int cycles, output int low);
    cycles = 0;
    low = 0;
    while (!o_valid && cycles < 200) begin
      if (!o_ready) low++;
      step();
      cycles++;
    end
  endtask

  typedef struct {
    logic [W-1:0] alu;
    logic [2:0]   sel;
    logic         we;
    logic         nzp_we;
    logic [2:0]   exp_nzp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int low;
    int pulses;

    // ---- reset ----
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_nzp", W'(o_nzp), W'(3'b010));
    check("rst_rd_we", W'(o_rd_we), W'(0));
    check("rst_rd_sel", W'(o_rd_sel), W'(0));
    check("rst_rd_data", o_rd_data, W'(0));

    // ---- ADD pass-through ----
    send(INSN_ADD, 64'd5, '0, '0, 3'd3, 1'b1, 1'b1);
    step();
    idle();
    check("add_valid", W'(o_valid), W'(1));
    check("add_data", o_rd_data, 64'd5);
    check("add_sel", W'(o_rd_sel), W'(3));
    check("add_we", W'(o_rd_we), W'(1));
    check("add_nzp", W'(o_nzp), W'(3'b001));
    step();
    check("add_pulse_end", W'(o_valid), W'(0));
    check("add_we_gated", W'(o_rd_we), W'(0));
    check("add_data_hold", o_rd_data, 64'd5);

    // ---- MUL 7 * -3 ----
    send(INSN_MUL, '0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3'd2, 1'b1, 1'b1);
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    check("mul_mid_ready", W'(o_ready), W'(0));
    check("mul_mid_nzp", W'(o_nzp), W'(3'b001));
    wait_valid(cyc, low);
    check("mul_valid", W'(o_valid), W'(1));
    check("mul_latency", W'(cyc + 10), W'(64));
    check("mul_ready_low", W'(low + 10), W'(64));
    check("mul_data", o_rd_data, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_sel", W'(o_rd_sel), W'(2));
    check("mul_nzp", W'(o_nzp), W'(3'b100));
    check("mul_ready_at_valid", W'(o_ready), W'(1));

    // ---- streaming pass-throughs, one per cycle ----
    vecs[0] = '{64'd0,                  3'd5, 1'b1, 1'b1, 3'b010};
    vecs[1] = '{64'h8000_0000_0000_0000, 3'd4, 1'b1, 1'b1, 3'b100};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 3'd6, 1'b0, 1'b0, 3'b100};
    vecs[3] = '{64'd1,                  3'd7, 1'b1, 1'b1, 3'b001};
    step();
    for (int i = 0; i < 4; i++) begin
      send(INSN_ADD, vecs[i].alu, '0, '0, vecs[i].sel, vecs[i].we, vecs[i].nzp_we);
      step();
      check($sformatf("stream%0d_valid", i), W'(o_valid), W'(1));
      check($sformatf("stream%0d_data", i), o_rd_data, vecs[i].alu);
      check($sformatf("stream%0d_sel", i), W'(o_rd_sel), W'(vecs[i].sel));
      check($sformatf("stream%0d_we", i), W'(o_rd_we), W'(vecs[i].we));
      check($sformatf("stream%0d_nzp", i), W'(o_nzp), W'(vecs[i].exp_nzp));
    end
    idle();
    step();

    // ---- back-to-back: MUL 0*5 then CMP in the retire cycle ----
    send(INSN_MUL, '0, 64'd0, 64'd5, 3'd1, 1'b1, 1'b1);
    step();
    idle();
    wait_valid(cyc, low);
    check("b2b_mul_valid", W'(o_valid), W'(1));
    check("b2b_mul_latency", W'(cyc), W'(64));
    check("b2b_mul_data", o_rd_data, 64'd0);
    check("b2b_mul_nzp", W'(o_nzp), W'(3'b010));
    check("b2b_ready", W'(o_ready), W'(1));
    send(INSN_CMP, 64'd0, '0, '0, 3'd0, 1'b0, 1'b1);
    step();
    check("b2b_cmp_valid", W'(o_valid), W'(1));
    check("b2b_cmp_we", W'(o_rd_we), W'(0));
    check("b2b_cmp_nzp", W'(o_nzp), W'(3'b010));
    send(INSN_CMP, {W{1'b1}}, '0, '0, 3'd0, 1'b0, 1'b1);
    step();
    idle();
    check("cmp_neg_valid", W'(o_valid), W'(1));
    check("cmp_neg_we", W'(o_rd_we), W'(0));
    check("cmp_neg_nzp", W'(o_nzp), W'(3'b100));
    step();

    // ---- flush mid-MUL, with a coincident instruction ----
    send(INSN_MUL, '0, 64'd3, 64'd4, 3'd2, 1'b1, 1'b1);
    step();
    idle();
    for (int i = 0; i < 29; i++) step();
    check("flush_pre_ready", W'(o_ready), W'(0));
    i_flush = 1'b1;
    send(INSN_ADD, 64'd7, '0, '0, 3'd3, 1'b1, 1'b1);
    step();
    i_flush = 1'b0;
    idle();
    check("flush_valid", W'(o_valid), W'(0));
    check("flush_ready", W'(o_ready), W'(1));
    check("flush_nzp", W'(o_nzp), W'(3'b100));
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (o_valid) pulses++;
      step();
    end
    check("flush_no_retire", W'(pulses), W'(0));
    i_flush = 1'b1;
    send(INSN_ADD, 64'd7, '0, '0, 3'd3, 1'b1, 1'b1);
    step();
    i_flush = 1'b0;
    idle();
    check("flush_drop_valid", W'(o_valid), W'(0));
    check("flush_drop_nzp", W'(o_nzp), W'(3'b100));
    check("flush_drop_data", o_rd_data, {W{1'b1}});

    // ---- reset mid-MUL ----
    send(INSN_MUL, '0, 64'd2, 64'd3, 3'd5, 1'b1, 1'b1);
    step();
    idle();
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    check("rstmul_valid", W'(o_valid), W'(0));
    check("rstmul_nzp", W'(o_nzp), W'(3'b010));
    check("rstmul_data", o_rd_data, W'(0));
    check("rstmul_sel", W'(o_rd_sel), W'(0));
    check("rstmul_we", W'(o_rd_we), W'(0));
    rst_n = 1'b1;
    check("rstmul_ready", W'(o_ready), W'(1));
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      if (o_valid) pulses++;
      step();
    end
    check("rstmul_no_retire", W'(pulses), W'(0));

    // ---- nzp hold when nzp_we=0 ----
    send(INSN_ADD, {W{1'b1}}, '0, '0, 3'd6, 1'b1, 1'b0);
    step();
    idle();
    check("hold_valid", W'(o_valid), W'(1));
    check("hold_data", o_rd_data, {W{1'b1}});
    check("hold_sel", W'(o_rd_sel), W'(6));
    check("hold_nzp", W'(o_nzp), W'(3'b010));
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lc4_writeback.md
# lc4_writeback

Execute-to-writeback stage sitting directly downstream of `lc4_alu`. It registers the ALU result, destination register and write enable, and computes the LC4 NZP condition code. It also implements the MUL opcode, which the combinational ALU returns as 0, using a fixed-latency iterative shift-add multiplier. While a multiply is in flight, the stage stalls upstream through a valid/ready handshake.

## Interface
- `WORD_SIZE`, default 64: datapath width of operands, ALU result and writeback data.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `i_valid`  in  1  upstream presents an instruction this cycle.
- `o_ready`  out  1  stage can accept; a transfer occurs when `i_valid && o_ready` at a rising edge.
- `i_flush`  in  1  kill in-flight and incoming instruction (branch mispredict).
- `i_insn`  in  16  instruction word, same encoding the ALU decodes.
- `i_alu_result`  in  WORD_SIZE  `lc4_alu` `o_result` for `i_insn`.
- `i_r1data`, `i_r2data`  in  WORD_SIZE  source operands; used only for MUL.
- `i_rd_sel`  in  3  destination register index.
- `i_rd_we`  in  1  instruction writes a register.
- `i_nzp_we`  in  1  instruction updates NZP (register writes and CMP).
- `o_valid`  out  1  one-cycle pulse; `o_rd_*` valid this cycle.
- `o_rd_we`  out  1  register-file write enable; equals `i_rd_we` of the retiring instruction, gated by `o_valid`.
- `o_rd_sel`  out  3  register-file write index.
- `o_rd_data`  out  WORD_SIZE  writeback data.
- `o_nzp`  out  3  architectural condition code {N,Z,P}; holds between updates.

## Operation
- **MUL decode.** MUL is `i_insn[15:12]==4'b0001 && i_insn[5:3]==3'b001`. All other instructions are pass-through.
- **States: IDLE, MUL.**
- **IDLE.**
  - `o_ready=1`.
  - On a pass-through transfer: register `i_alu_result`, `i_rd_sel` and `i_rd_we`; assert `o_valid` next cycle; stay in IDLE.
  - On a MUL transfer: load acc=0, mcand=`i_r1data`, mplier=`i_r2data`, count=`WORD_SIZE`; capture `i_rd_sel`, `i_rd_we` and `i_nzp_we`; go to MUL.
- **MUL.**
  - `o_ready=0`.
  - Each cycle: if mplier[0] then acc += mcand (mod 2^WORD_SIZE); then mcand <<= 1, mplier >>= 1, count -= 1.
  - On the edge where count goes 1→0: drive result = final acc, assert `o_valid` next cycle, return to IDLE.
  - No early termination; latency is fixed.
- **Result.** Low WORD_SIZE bits of the product, identical for signed and unsigned operands.
- **NZP update.** On every `o_valid` with nzp_we=1:
  - N=result[WORD_SIZE-1]
  - Z=(result==0)
  - P=!N&&!Z
  - Otherwise `o_nzp` holds.
- **NZP on pass-through.** `i_nzp_we` and `i_alu_result` are taken together. CMP's ±1/0 result sets NZP correctly with `i_rd_we=0`.
- **Output registers.** `o_rd_data` and `o_rd_sel` hold their last value when `o_valid=0`. `o_rd_we` is 0 whenever `o_valid=0`.
- **Flush.**
  - `i_flush=1` at an edge forces IDLE, clears any pending `o_valid`, and leaves `o_nzp` unchanged.
  - An instruction presented in the same cycle is dropped, even if `o_ready=1`.
  - Flush takes priority over transfer and over MUL completion.
- **No downstream backpressure.** The register file always accepts.

## Timing
- **Reset values** (`rst_n=0` at an edge): state=IDLE, `o_ready=1`, `o_valid=0`, `o_rd_we=0`, `o_rd_sel=0`, `o_rd_data=0`, `o_nzp=3'b010`, multiplier registers 0.
- **Reset mid-MUL** discards the multiply with no `o_valid`. `o_ready` is 1 in the first cycle after reset deasserts.
- **Pass-through latency.** Transfer at edge E gives `o_valid=1` in the cycle after E. Throughput is one instruction per cycle.
- **MUL latency.**
  - Transfer at edge E gives `o_valid=1` in the cycle after edge E+WORD_SIZE (WORD_SIZE+1 edges total).
  - `o_ready=0` from after E through the cycle before `o_valid`.
  - `o_ready=1` in the `o_valid` cycle, so a back-to-back accept is legal in that cycle.
- **`o_nzp` timing.** Updates in the same cycle `o_valid` rises.

## Test plan
- **Reset.** Hold `rst_n=0` 2 cycles, then release → `o_nzp=010`, `o_valid=0`, `o_ready=1`.
- **ADD pass-through.** ADD with `i_alu_result=5`, rd_sel=3, we=1, nzp_we=1 → next cycle `o_valid=1`, `o_rd_data=5`, `o_rd_sel=3`, `o_nzp=001`.
- **MUL.** MUL with r1=7, r2=-3 (0xFFFF_FFFF_FFFF_FFFD) → `o_ready=0` for 64 cycles, then `o_valid=1`, `o_rd_data=0xFFFF_FFFF_FFFF_FFEB`, `o_nzp=100`.
- **Back-to-back.** MUL 0×5 followed immediately by pass-through CMP result 0 with rd_we=0 → MUL retires with data 0, NZP 010. CMP is accepted in that same cycle and retires next cycle with `o_rd_we=0`, NZP 010.
- **Flush mid-MUL.** Flush on cycle 30 of a MUL → no `o_valid`, `o_nzp` unchanged, `o_ready=1` next cycle. A flush coinciding with a new `i_valid` drops that instruction.
- **Reset mid-MUL and nzp hold.** Assert `rst_n=0` during a MUL → all outputs at reset values. A pass-through with nzp_we=0 and result -1 leaves `o_nzp` unchanged.
